exception_unit: RTL and testbench

- Consumer end of the per-stage exception vector that travels the pipeline registers.
- Sits at the MEM/commit boundary. It merges the in-pipe exception flags with synchronized external interrupts into the full exception type, prioritizes them and computes ExcCode/EPC/BadVAddr.
- On commit it issues one registered flush/redirect to the pipeline and a one-cycle write strobe to CP0. ERET is also committed here.

---
 rtl/exception_unit_pkg.sv | 40 ++++
 rtl/int_sync.sv | 25 ++
 rtl/exception_unit.sv | 113 +++++++++++
 tb/tb_exception_unit.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/exception_unit_pkg.sv
// Shared types and cause codes for the MEM/commit exception unit.
package exception_unit_pkg;

  // Per-stage exception flags carried down the pipeline registers (MSB first).
  typedef struct packed {
    logic wrong_addr_if;
    logic reserved_instr;
    logic overflow;
    logic syscall;
    logic brk;
    logic wrong_addr_mem;
  } except_in_pipe_t;

  typedef struct packed {
    logic            interrupt;
    except_in_pipe_t pipe;
  } except_t;

  localparam logic [4:0] EXC_INT  = 5'd0;
  localparam logic [4:0] EXC_ADEL = 5'd4;
  localparam logic [4:0] EXC_ADES = 5'd5;
  localparam logic [4:0] EXC_SYS  = 5'd8;
  localparam logic [4:0] EXC_BP   = 5'd9;
  localparam logic [4:0] EXC_RI   = 5'd10;
  localparam logic [4:0] EXC_OV   = 5'd12;

  typedef enum logic {IDLE, COMMIT} state_t;

  // Highest-priority cause wins; caller guarantees at least one flag is set.
  function automatic logic [4:0] exc_code(input except_t e, input logic is_store);
    if (e.interrupt)                exc_code = EXC_INT;
    else if (e.pipe.wrong_addr_if)  exc_code = EXC_ADEL;
    else if (e.pipe.reserved_instr) exc_code = EXC_RI;
    else if (e.pipe.overflow)       exc_code = EXC_OV;
    else if (e.pipe.syscall)        exc_code = EXC_SYS;
    else if (e.pipe.brk)            exc_code = EXC_BP;
    else                            exc_code = is_store ? EXC_ADES : EXC_ADEL;
  endfunction

endpackage

// File: rtl/int_sync.sv
// Multi-flop synchronizer for the asynchronous hardware interrupt lines.
module int_sync #(
  parameter int DEPTH = 2,
  parameter int W     = 6
) (
  input  logic         clk,
  input  logic         resetn,
  input  logic [W-1:0] i_d,
  output logic [W-1:0] o_q
);

  logic [DEPTH-1:0][W-1:0] r_ff;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_ff <= '0;
    end else begin
      r_ff[0] <= i_d;
      for (int i = 1; i < DEPTH; i++) r_ff[i] <= r_ff[i-1];
    end
  end

  assign o_q = r_ff[DEPTH-1];

endmodule

// File: rtl/exception_unit.sv
// Commit-point exception/ERET handler: prioritizes causes, drives CP0 update
// strobes and a single registered flush/redirect per committed event.
module exception_unit
  import exception_unit_pkg::*;
#(
  parameter logic [31:0] EXC_VECTOR  = 32'hBFC0_0380,
  parameter int          SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        MEM_Valid,
  input  logic        MEM_Stall,
  input  logic [5:0]  MEM_Except,
  input  logic        MEM_IsStore,
  input  logic        MEM_IsEret,
  input  logic        MEM_InDelaySlot,
  input  logic [31:0] MEM_PC,
  input  logic [31:0] MEM_ALUOut,
  input  logic [5:0]  Ext_Int,
  input  logic        CP0_Status_IE,
  input  logic        CP0_Status_EXL,
  input  logic [7:0]  CP0_Status_IM,
  input  logic [1:0]  CP0_Cause_IP_SW,
  input  logic [31:0] CP0_EPC,
  output logic [5:0]  HW_IP,
  output logic        Exc_Valid,
  output logic [4:0]  Exc_Code,
  output logic        Exc_BD,
  output logic [31:0] Exc_EPC,
  output logic        Exc_EPCWr,
  output logic [31:0] Exc_BadVAddr,
  output logic        Exc_BadVAddrWr,
  output logic        Eret_Commit,
  output logic        Flush,
  output logic        Redirect_Valid,
  output logic [31:0] Redirect_PC
);

  state_t    r_state, w_state_nxt;
  logic      w_int_req, w_take, w_any, w_eret_only;
  except_t   w_exc;
  logic [4:0] w_code;

  int_sync #(.DEPTH(SYNC_STAGES), .W(6)) u_int_sync (
    .clk    (clk),
    .resetn (resetn),
    .i_d    (Ext_Int),
    .o_q    (HW_IP)
  );

  assign w_int_req   = CP0_Status_IE & ~CP0_Status_EXL &
                       (|({HW_IP, CP0_Cause_IP_SW} & CP0_Status_IM));
  assign w_exc       = {w_int_req, MEM_Except};
  assign w_any       = |w_exc;
  // Only an idle, live, moving instruction may commit; in COMMIT the MEM slot
  // holds a younger instruction that is being flushed.
  assign w_take      = (r_state == IDLE) & MEM_Valid & ~MEM_Stall;
  assign w_eret_only = MEM_IsEret & ~w_any;
  assign w_code      = exc_code(w_exc, MEM_IsStore);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) r_state <= IDLE;
    else         r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = IDLE;
    if (r_state == IDLE && w_take && (w_any || MEM_IsEret)) w_state_nxt = COMMIT;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      Exc_Valid      <= 1'b0;
      Exc_Code       <= '0;
      Exc_BD         <= 1'b0;
      Exc_EPC        <= '0;
      Exc_EPCWr      <= 1'b0;
      Exc_BadVAddr   <= '0;
      Exc_BadVAddrWr <= 1'b0;
      Eret_Commit    <= 1'b0;
      Flush          <= 1'b0;
      Redirect_Valid <= 1'b0;
      Redirect_PC    <= '0;
    end else begin
      Exc_Valid      <= 1'b0;
      Exc_BD         <= 1'b0;
      Exc_EPCWr      <= 1'b0;
      Exc_BadVAddrWr <= 1'b0;
      Eret_Commit    <= 1'b0;
      Flush          <= 1'b0;
      Redirect_Valid <= 1'b0;
      Redirect_PC    <= '0;
      if (w_take && w_any) begin
        Exc_Valid      <= 1'b1;
        Exc_Code       <= w_code;
        Exc_BD         <= MEM_InDelaySlot;
        Exc_EPC        <= MEM_InDelaySlot ? (MEM_PC - 32'd4) : MEM_PC;
        Exc_EPCWr      <= ~CP0_Status_EXL;
        Exc_BadVAddr   <= w_exc.pipe.wrong_addr_if ? MEM_PC : MEM_ALUOut;
        Exc_BadVAddrWr <= (w_code == EXC_ADEL) || (w_code == EXC_ADES);
        Flush          <= 1'b1;
        Redirect_Valid <= 1'b1;
        Redirect_PC    <= EXC_VECTOR;
      end else if (w_take && w_eret_only) begin
        Eret_Commit    <= 1'b1;
        Flush          <= 1'b1;
        Redirect_Valid <= 1'b1;
        Redirect_PC    <= CP0_EPC;
      end
    end
  end

endmodule

// File: tb/tb_exception_unit.sv
// Directed test-plan cases plus randomized traffic against a priority-table model.
module tb_exception_unit;

  logic        clk = 1'b0;
  logic        resetn;
  logic        MEM_Valid, MEM_Stall, MEM_IsStore, MEM_IsEret, MEM_InDelaySlot;
  logic [5:0]  MEM_Except, Ext_Int;
  logic [31:0] MEM_PC, MEM_ALUOut, CP0_EPC;
  logic        CP0_Status_IE, CP0_Status_EXL;
  logic [7:0]  CP0_Status_IM;
  logic [1:0]  CP0_Cause_IP_SW;
  logic [5:0]  HW_IP;
  logic        Exc_Valid, Exc_BD, Exc_EPCWr, Exc_BadVAddrWr, Eret_Commit, Flush, Redirect_Valid;
  logic [4:0]  Exc_Code;
  logic [31:0] Exc_EPC, Exc_BadVAddr, Redirect_PC;

  int n_vec = 0;
  int n_bad = 0;

  exception_unit dut (
    .clk(clk), .resetn(resetn),
    .MEM_Valid(MEM_Valid), .MEM_Stall(MEM_Stall), .MEM_Except(MEM_Except),
    .MEM_IsStore(MEM_IsStore), .MEM_IsEret(MEM_IsEret), .MEM_InDelaySlot(MEM_InDelaySlot),
    .MEM_PC(MEM_PC), .MEM_ALUOut(MEM_ALUOut), .Ext_Int(Ext_Int),
    .CP0_Status_IE(CP0_Status_IE), .CP0_Status_EXL(CP0_Status_EXL),
    .CP0_Status_IM(CP0_Status_IM), .CP0_Cause_IP_SW(CP0_Cause_IP_SW), .CP0_EPC(CP0_EPC),
    .HW_IP(HW_IP), .Exc_Valid(Exc_Valid), .Exc_Code(Exc_Code), .Exc_BD(Exc_BD),
    .Exc_EPC(Exc_EPC), .Exc_EPCWr(Exc_EPCWr), .Exc_BadVAddr(Exc_BadVAddr),
    .Exc_BadVAddrWr(Exc_BadVAddrWr), .Eret_Commit(Eret_Commit), .Flush(Flush),
    .Redirect_Valid(Redirect_Valid), .Redirect_PC(Redirect_PC)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %h expected %h", tag, $time, obs, exp);
    end
  endtask

  // Reference model state
  bit          m_commit;
  logic [5:0]  m_ip_hist [2];   // [0]=sampled one edge ago, [1]=two edges ago (visible on HW_IP)
  logic        e_valid, e_bd, e_epcwr, e_bvawr, e_eret, e_flush, e_rv;
  logic [4:0]  e_code;
  logic [31:0] e_epc, e_bva, e_rpc;

  task automatic model_reset();
    m_commit = 0;
    m_ip_hist[0] = '0; m_ip_hist[1] = '0;
    e_code = '0; e_epc = '0; e_bva = '0;
  endtask

  // Cause table in priority order: bit 6 = interrupt ... bit 0 = data address error.
  function automatic logic [4:0] cause_code(input int b, input logic st);
    case (b)
      6: return 5'd0;
      5: return 5'd4;
      4: return 5'd10;
      3: return 5'd12;
      2: return 5'd8;
      1: return 5'd9;
      default: return st ? 5'd5 : 5'd4;
    endcase
  endfunction

  task automatic step();
    logic [6:0] fl;
    logic       take, ireq;
    int         k;
    ireq = CP0_Status_IE && !CP0_Status_EXL && (({m_ip_hist[1], CP0_Cause_IP_SW} & CP0_Status_IM) != 0);
    fl   = {ireq, MEM_Except};
    take = !m_commit && MEM_Valid && !MEM_Stall;
    k = -1;
    for (int i = 6; i >= 0; i--) if (fl[i] && k < 0) k = i;
    {e_valid, e_bd, e_epcwr, e_bvawr, e_eret, e_flush, e_rv} = '0;
    e_rpc = '0;
    if (take && k >= 0) begin
      e_valid = 1; e_flush = 1; e_rv = 1; e_rpc = 32'hBFC0_0380;
      e_code  = cause_code(k, MEM_IsStore);
      e_bd    = MEM_InDelaySlot;
      e_epc   = MEM_InDelaySlot ? MEM_PC - 32'd4 : MEM_PC;
      e_epcwr = !CP0_Status_EXL;
      e_bvawr = (e_code == 5'd4) || (e_code == 5'd5);
      e_bva   = (k == 5) ? MEM_PC : MEM_ALUOut;
    end else if (take && MEM_IsEret) begin
      e_eret = 1; e_flush = 1; e_rv = 1; e_rpc = CP0_EPC;
    end
    m_commit = take && (k >= 0 || MEM_IsEret);
    @(posedge clk);
    m_ip_hist[1] = m_ip_hist[0];
    m_ip_hist[0] = Ext_Int;
    #1;
    chk("hw_ip", HW_IP, m_ip_hist[1]);
    chk("exc_valid", Exc_Valid, e_valid);
    chk("epc_wr", Exc_EPCWr, e_epcwr);
    chk("bva_wr", Exc_BadVAddrWr, e_bvawr);
    chk("eret", Eret_Commit, e_eret);
    chk("flush", Flush, e_flush);
    chk("redir_v", Redirect_Valid, e_rv);
    chk("exc_code", Exc_Code, e_code);
    chk("exc_epc", Exc_EPC, e_epc);
    if (e_rv)    chk("redir_pc", Redirect_PC, e_rpc);
    if (e_valid) chk("exc_bd", Exc_BD, e_bd);
    if (e_bvawr) chk("badvaddr", Exc_BadVAddr, e_bva);
    @(negedge clk);
  endtask

  task automatic idle();
    MEM_Valid = 0; MEM_Stall = 0; MEM_Except = '0; MEM_IsStore = 0; MEM_IsEret = 0;
    MEM_InDelaySlot = 0; MEM_PC = '0; MEM_ALUOut = '0; Ext_Int = '0;
    CP0_Status_IE = 0; CP0_Status_EXL = 0; CP0_Status_IM = '0; CP0_Cause_IP_SW = '0; CP0_EPC = '0;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_valid"}, Exc_Valid, 0);
    chk({tag, "_flush"}, Flush, 0);
    chk({tag, "_rv"}, Redirect_Valid, 0);
    chk({tag, "_rpc"}, Redirect_PC, 0);
    chk({tag, "_eret"}, Eret_Commit, 0);
    chk({tag, "_code"}, Exc_Code, 0);
    chk({tag, "_epc"}, Exc_EPC, 0);
    chk({tag, "_bva"}, Exc_BadVAddr, 0);
    chk({tag, "_hwip"}, HW_IP, 0);
    chk({tag, "_epcwr"}, Exc_EPCWr, 0);
    chk({tag, "_bvawr"}, Exc_BadVAddrWr, 0);
    chk({tag, "_bd"}, Exc_BD, 0);
  endtask

  initial begin
    idle();
    resetn = 0;
    model_reset();
    Ext_Int = 6'h3F;
    repeat (3) @(posedge clk);
    #1 chk_all_zero("rst");
    Ext_Int = '0;
    @(negedge clk);
    resetn = 1;

    // Overflow, not in delay slot
    MEM_Valid = 1; MEM_Except = 6'b001000; MEM_PC = 32'h8000_0100;
    step();
    chk("ov_code", Exc_Code, 12);
    chk("ov_epc", Exc_EPC, 32'h8000_0100);
    chk("ov_rpc", Redirect_PC, 32'hBFC0_0380);
    chk("ov_epcwr", Exc_EPCWr, 1);
    idle(); step();
    chk("ov_after", Exc_Valid, 0);

    // Store address error in delay slot
    MEM_Valid = 1; MEM_Except = 6'b000001; MEM_IsStore = 1; MEM_ALUOut = 32'h1003;
    MEM_InDelaySlot = 1; MEM_PC = 32'h8000_0204;
    step();
    chk("ades_code", Exc_Code, 5);
    chk("ades_bva", Exc_BadVAddr, 32'h1003);
    chk("ades_epc", Exc_EPC, 32'h8000_0200);
    chk("ades_bd", Exc_BD, 1);
    idle(); step();

    // Interrupt beats RI once synchronized; stall holds off commit
    MEM_Valid = 1; MEM_Except = 6'b010000; MEM_PC = 32'h8000_0300;
    Ext_Int = 6'b000001; CP0_Status_IE = 1; CP0_Status_IM = 8'h04; MEM_Stall = 1;
    repeat (3) begin
      step();
      chk("int_stalled", Exc_Valid, 0);
    end
    MEM_Stall = 0;
    step();
    chk("int_valid", Exc_Valid, 1);
    chk("int_code", Exc_Code, 0);
    idle(); repeat (3) step();

    // ERET
    MEM_Valid = 1; MEM_IsEret = 1; CP0_EPC = 32'h8000_0400;
    step();
    chk("eret_commit", Eret_Commit, 1);
    chk("eret_rpc", Redirect_PC, 32'h8000_0400);
    chk("eret_excv", Exc_Valid, 0);
    idle(); step();

    // Back-to-back: Break during COMMIT is masked
    MEM_Valid = 1; MEM_Except = 6'b000100; MEM_PC = 32'h8000_0500;
    step();
    chk("sys_code", Exc_Code, 8);
    MEM_Except = 6'b000010; MEM_PC = 32'h8000_0504;
    step();
    chk("brk_masked", Exc_Valid, 0);
    idle(); step();

    // Syscall under EXL, then reset during COMMIT
    MEM_Valid = 1; MEM_Except = 6'b000100; CP0_Status_EXL = 1; MEM_PC = 32'h8000_0600;
    step();
    chk("exl_valid", Exc_Valid, 1);
    chk("exl_epcwr", Exc_EPCWr, 0);
    idle();
    resetn = 0;
    #1 chk_all_zero("midrst");
    model_reset();
    @(posedge clk);
    @(negedge clk);
    resetn = 1;
    step();
    step();

    // Randomized traffic
    for (int c = 0; c < 600; c++) begin
      MEM_Valid       = ($urandom_range(0, 3) != 0);
      MEM_Stall       = ($urandom_range(0, 3) == 0);
      MEM_Except      = ($urandom_range(0, 2) == 0) ? 6'($urandom) : 6'd0;
      MEM_IsStore     = 1'($urandom);
      MEM_IsEret      = ($urandom_range(0, 5) == 0);
      MEM_InDelaySlot = 1'($urandom);
      MEM_PC          = $urandom;
      MEM_ALUOut      = $urandom;
      if ($urandom_range(0, 7) == 0) Ext_Int = 6'($urandom);
      CP0_Status_IE   = 1'($urandom);
      CP0_Status_EXL  = ($urandom_range(0, 3) == 0);
      CP0_Status_IM   = 8'($urandom);
      CP0_Cause_IP_SW = ($urandom_range(0, 7) == 0) ? 2'($urandom) : 2'd0;
      CP0_EPC         = $urandom;
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
